// File: rtl/mult_pkg.sv
// Shared types and sizing for the multiplier display path.
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} conv_state_t;
  localparam int BCD_DIGITS = 5;
  localparam int PROD_WIDTH = 16;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is shifted.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for the multiplier product, one bit per clock.
// state | meaning
// IDLE  | waiting for Start, outputs hold the last result
// SHIFT | one double-dabble step per edge, IN_WIDTH edges total
// DONE  | publish work digits and sign, pulse Done
module product_bcd_converter
  import mult_pkg::*;
#(
  parameter int IN_WIDTH = PROD_WIDTH,
  parameter int DIGITS   = BCD_DIGITS,
  parameter bit SIGNED   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [IN_WIDTH/2-1:0] AVal,
  input  logic [IN_WIDTH/2-1:0] BVal,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Sign,
  output logic [4*DIGITS-1:0]   Bcd
);
  localparam int CNT_W = $clog2(IN_WIDTH);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

  conv_state_t         state_q, state_d;
  logic [IN_WIDTH-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]    work_q, work_d;
  logic [BCD_W-1:0]    work_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_r_q, sign_r_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sign_q, sign_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [IN_WIDTH-1:0] prod;
  logic                shift_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work_q[4*g +: 4]),
      .dout (work_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    sign_r_d     = sign_r_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sign_d       = sign_q;
    bcd_d        = bcd_q;
    shift_unused = 1'b0;
    prod         = {AVal, BVal};
    case (state_q)
      IDLE: begin
        if (Start) begin
          // Unsigned negate in IN_WIDTH bits, so the most negative value maps onto itself.
          mag_d    = (SIGNED && prod[IN_WIDTH-1]) ? -prod : prod;
          sign_r_d = SIGNED & AVal[IN_WIDTH/2-1];
          work_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        {shift_unused, work_d, mag_d} = {work_adj, mag_q, 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        bcd_d   = work_q;
        sign_d  = sign_r_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sign_r_q <= sign_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
      bcd_q    <= bcd_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sign = sign_q;
  assign Bcd  = bcd_q;
endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and randomized checks of the product BCD converter, signed and unsigned builds.
module tb_product_bcd_converter;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        s_start = 1'b0, u_start = 1'b0;
  logic [7:0]  s_a = '0, s_b = '0, u_a = '0, u_b = '0;
  logic        s_busy, s_done, s_sign, u_busy, u_done, u_sign;
  logic [19:0] s_bcd, u_bcd;
  int          tests = 0;
  int          fails = 0;

  always #5 Clk = ~Clk;

  product_bcd_converter #(.IN_WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .Start(s_start), .AVal(s_a), .BVal(s_b),
    .Busy(s_busy), .Done(s_done), .Sign(s_sign), .Bcd(s_bcd)
  );

  product_bcd_converter #(.IN_WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) dut_u (
    .Clk(Clk), .Reset_n(Reset_n), .Start(u_start), .AVal(u_a), .BVal(u_b),
    .Busy(u_busy), .Done(u_done), .Sign(u_sign), .Bcd(u_bcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned m);
    logic [19:0] r;
    int unsigned v;
    v = m;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves time just after the sampling edge E0.
  task automatic start_s(input logic [15:0] v);
    s_a = v[15:8];
    s_b = v[7:0];
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic wait_done_s(output int lat);
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (s_done) break;
    end
  endtask

  task automatic conv_s(input string tag, input logic [15:0] v, input logic exp_sign,
                        input logic [19:0] exp_bcd);
    int lat;
    start_s(v);
    wait_done_s(lat);
    check({tag, "_lat"}, lat, 17);
    check({tag, "_sign"}, s_sign, exp_sign);
    check({tag, "_bcd"}, s_bcd, exp_bcd);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [15:0] v;
    int sv;

    tick();
    tick();
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_sign", s_sign, 0);
    check("rst_bcd", s_bcd, 0);
    Reset_n = 1'b1;
    tick();

    // Basic conversion with latency and Busy window
    start_s(16'h0007);
    check("t1_busy_e0", s_busy, 1);
    wait_done_s(lat);
    check("t1_lat", lat, 17);
    check("t1_sign", s_sign, 0);
    check("t1_bcd", s_bcd, 20'h00007);
    check("t1_busy_e17", s_busy, 0);
    tick();
    check("t1_done_1cyc", s_done, 0);

    conv_s("neg7", 16'hFFF9, 1'b1, 20'h00007);
    conv_s("sq127", 16'h3F01, 1'b0, 20'h16129);
    conv_s("min", 16'h8000, 1'b1, 20'h32768);
    conv_s("max", 16'h7FFF, 1'b0, 20'h32767);
    conv_s("zero", 16'h0000, 1'b0, 20'h00000);

    // Starts while busy are ignored; back-to-back start at E18 is accepted
    start_s(16'h0123);
    ndone = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (s_done) ndone++;
      s_start = 1'b0;
      if (k == 2 || k == 15) begin
        s_a = 8'h09;
        s_b = 8'h99;
        s_start = 1'b1;
      end
    end
    check("ign_done_at17", s_done, 1);
    check("ign_ndone", ndone, 1);
    check("ign_bcd", s_bcd, 20'h00291);
    s_a = 8'h00;
    s_b = 8'h42;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("b2b_busy", s_busy, 1);
    check("b2b_hold_bcd", s_bcd, 20'h00291);
    wait_done_s(lat);
    check("b2b_lat", lat, 17);
    check("b2b_bcd", s_bcd, 20'h00066);

    // Reset mid-conversion
    conv_s("pre_rst", 16'hFF85, 1'b1, 20'h00123);
    start_s(16'h1234);
    repeat (7) tick();
    Reset_n = 1'b0;
    tick();
    check("rst_mid_busy", s_busy, 0);
    check("rst_mid_bcd", s_bcd, 0);
    check("rst_mid_sign", s_sign, 0);
    check("rst_mid_done", s_done, 0);
    Reset_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      tick();
      if (s_done) ndone++;
    end
    check("rst_mid_nodone", ndone, 0);

    // Start under reset
    Reset_n = 1'b0;
    start_s(16'h0005);
    check("rst_start_busy", s_busy, 0);
    Reset_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      tick();
      if (s_done || s_busy) ndone++;
    end
    check("rst_start_idle", ndone, 0);

    // Unsigned build
    u_a = 8'hFF;
    u_b = 8'hFF;
    u_start = 1'b1;
    tick();
    u_start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (u_done) break;
    end
    check("u_lat", lat, 17);
    check("u_sign", u_sign, 0);
    check("u_bcd", u_bcd, 20'h65535);

    // Random operands on both builds started together
    for (int n = 0; n < 1000; n++) begin
      v = 16'($urandom);
      sv = int'($signed(v));
      u_a = v[15:8];
      u_b = v[7:0];
      u_start = 1'b1;
      start_s(v);
      u_start = 1'b0;
      wait_done_s(lat);
      check("rnd_lat", lat, 17);
      check("rnd_sign", s_sign, (sv < 0) ? 1 : 0);
      check("rnd_bcd", s_bcd, to_bcd((sv < 0) ? -sv : sv));
      check("rnd_u_done", u_done, 1);
      check("rnd_u_bcd", {u_sign, u_bcd}, {1'b0, to_bcd(int'(v))});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
